// File: rtl/sbox_pkg.sv
// Shared constants for the TRNG S-box compressor: group/nibble sizes and the
// fixed 5-to-4 substitution table.
package sbox_pkg;

  localparam int GROUP = 5;
  localparam int NIB   = 4;

  localparam logic [NIB-1:0] SBOX5 [32] = '{
    4'd9,  4'd0,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd15,
    4'd1,  4'd10, 4'd2,  4'd6,  4'd7,  4'd5,  4'd8,  4'd14,
    4'd3,  4'd12, 4'd6,  4'd13, 4'd5,  4'd7,  4'd1,  4'd9,
    4'd15, 4'd2,  4'd0,  4'd4,  4'd11, 4'd10, 4'd14, 4'd8
  };

endpackage

// File: rtl/sbox5_lookup.sv
// Combinational 5-bit to 4-bit S-box lookup, one instance per lane.
module sbox5_lookup
  import sbox_pkg::*;
(
  input  logic [GROUP-1:0] idx_i,
  output logic [NIB-1:0]   nib_o
);

  assign nib_o = SBOX5[idx_i];

endmodule

// File: rtl/sbox_stream_compressor.sv
// Serial raw-bit collector per lane, S-box compression of 5-bit groups, and an
// output FIFO with valid/ready handshake plus drop accounting.
module sbox_stream_compressor
  import sbox_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [LANES-1:0]         raw_bit_i,
  input  logic                     raw_valid_i,
  input  logic                     fold_en_i,
  input  logic                     clr_i,
  output logic [NIB*LANES-1:0]     d_out_o,
  output logic                     d_valid_o,
  input  logic                     d_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = NIB * LANES;

  logic [2:0]       cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [W-1:0]     stage_q, stage_d;
  logic             stage_valid_q, stage_valid_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [W-1:0]     mem [DEPTH];

  logic             accept, last_bit;
  logic             pop, push, drop, full;
  logic [W-1:0]     concat_word, fold_word;
  logic [NIB-1:0]   nib [LANES];
  logic [NIB-1:0]   sr_q [LANES];

  assign accept   = raw_valid_i & ~clr_i;
  assign last_bit = accept && (cnt_q == 3'(GROUP - 1));

  // Index includes the incoming bit so the group completes on its 5th bit.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [GROUP-1:0] idx;
    assign idx = {sr_q[gi], raw_bit_i[gi]};

    sbox5_lookup u_sbox (
      .idx_i (idx),
      .nib_o (nib[gi])
    );

    assign concat_word[gi*NIB +: NIB] = nib[gi];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sr_q[gi] <= '0;
      end else if (clr_i) begin
        sr_q[gi] <= '0;
      end else if (accept) begin
        sr_q[gi] <= idx[NIB-1:0];
      end
    end
  end

  always_comb begin
    fold_word = '0;
    for (int i = 0; i < LANES; i++) begin
      fold_word[NIB-1:0] = fold_word[NIB-1:0] ^ nib[i];
    end
  end

  assign full = (level_q == (AW+1)'(DEPTH));
  assign pop  = (level_q != '0) & d_ready_i & ~clr_i;
  assign push = stage_valid_q & ~clr_i & (~full | pop);
  assign drop = stage_valid_q & ~clr_i & ~push;

  always_comb begin
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    stage_d       = stage_q;
    stage_valid_d = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    ovf_d         = ovf_q;
    drop_cnt_d    = drop_cnt_q;
    if (clr_i) begin
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (accept) begin
        if (cnt_q == 3'd0) mode_d = fold_en_i;
        if (last_bit) begin
          cnt_d         = '0;
          stage_valid_d = 1'b1;
          stage_d       = mode_q ? fold_word : concat_word;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      ovf_q         <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      ovf_q         <= ovf_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Storage has no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= stage_q;
  end

  assign d_valid_o  = (level_q != '0);
  assign d_out_o    = d_valid_o ? mem[rd_ptr_q] : '0;
  assign level_o    = level_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_sbox_stream_compressor.sv
// Directed bench: table of single-group vectors plus hand-written sequences
// for mode latching, overflow, full push/pop, CLR and reset mid-group.
module tb_sbox_stream_compressor;

  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic [LANES-1:0] raw_bit_i = '0;
  logic             raw_valid_i = 1'b0;
  logic             fold_en_i = 1'b0;
  logic             clr_i = 1'b0;
  logic [4*LANES-1:0] d_out_o;
  logic             d_valid_o;
  logic             d_ready_i = 1'b0;
  logic [2:0]       level_o;
  logic             ovf_o;
  logic [15:0]      drop_cnt_o;

  int checks = 0;
  int errors = 0;

  sbox_stream_compressor #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .raw_bit_i   (raw_bit_i),
    .raw_valid_i (raw_valid_i),
    .fold_en_i   (fold_en_i),
    .clr_i       (clr_i),
    .d_out_o     (d_out_o),
    .d_valid_o   (d_valid_o),
    .d_ready_i   (d_ready_i),
    .level_o     (level_o),
    .ovf_o       (ovf_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0] l0;
    logic [4:0] l1;
    logic       fold;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Sends the top n bits (MSB first) of each lane pattern; fold_en is f0 on
  // the first bit and frest afterwards.
  task automatic send_bits(input logic [4:0] l0, input logic [4:0] l1, input int n,
                           input logic f0, input logic frest);
    for (int b = 4; b > 4 - n; b--) begin
      raw_bit_i   = {l1[b], l0[b]};
      raw_valid_i = 1'b1;
      fold_en_i   = (b == 4) ? f0 : frest;
      tick();
    end
    raw_valid_i = 1'b0;
    raw_bit_i   = '0;
  endtask

  task automatic pop_one();
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{l0: 5'd0,  l1: 5'd0,  fold: 1'b0, exp: 8'h99};
    vecs[1] = '{l0: 5'd31, l1: 5'd0,  fold: 1'b0, exp: 8'h98};
    vecs[2] = '{l0: 5'd22, l1: 5'd0,  fold: 1'b0, exp: 8'h91};
    vecs[3] = '{l0: 5'd3,  l1: 5'd24, fold: 1'b0, exp: 8'hFB};
    vecs[4] = '{l0: 5'd3,  l1: 5'd24, fold: 1'b1, exp: 8'h04};
    vecs[5] = '{l0: 5'd7,  l1: 5'd13, fold: 1'b1, exp: 8'h0A};
    vecs[6] = '{l0: 5'd16, l1: 5'd29, fold: 1'b0, exp: 8'hA3};

    tick();
    tick();
    check("reset_d_valid", 32'(d_valid_o), 32'd0);
    check("reset_d_out", 32'(d_out_o), 32'd0);
    check("reset_level", 32'(level_o), 32'd0);
    check("reset_ovf", 32'(ovf_o), 32'd0);
    check("reset_drop_cnt", 32'(drop_cnt_o), 32'd0);
    rst_n_i = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      send_bits(vecs[i].l0, vecs[i].l1, 5, vecs[i].fold, vecs[i].fold);
      check($sformatf("vec%0d_not_yet_valid", i), 32'(d_valid_o), 32'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(d_valid_o), 32'd1);
      check($sformatf("vec%0d_d_out", i), 32'(d_out_o), 32'(vecs[i].exp));
      check($sformatf("vec%0d_level", i), 32'(level_o), 32'd1);
      pop_one();
      check($sformatf("vec%0d_drained", i), 32'(level_o), 32'd0);
    end

    // Mode toggled mid-group: the word follows the mode sampled at bit 0.
    send_bits(5'd3, 5'd24, 5, 1'b0, 1'b1);
    tick();
    check("toggle_g1_concat", 32'(d_out_o), 32'h0FB);
    pop_one();
    send_bits(5'd3, 5'd24, 5, 1'b1, 1'b0);
    tick();
    check("toggle_g2_fold", 32'(d_out_o), 32'h004);
    pop_one();

    // Six groups with no consumer: four stored, two dropped.
    for (int k = 0; k < 6; k++) send_bits(5'(k), 5'd0, 5, 1'b0, 1'b0);
    tick();
    check("ovf_level", 32'(level_o), 32'd4);
    check("ovf_flag", 32'(ovf_o), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt_o), 32'd2);
    begin
      logic [7:0] exp_ovf [4];
      exp_ovf = '{8'h99, 8'h90, 8'h94, 8'h9B};
      for (int k = 0; k < 4; k++) begin
        check($sformatf("ovf_out%0d_valid", k), 32'(d_valid_o), 32'd1);
        check($sformatf("ovf_out%0d_data", k), 32'(d_out_o), 32'(exp_ovf[k]));
        pop_one();
      end
    end
    check("ovf_drained_valid", 32'(d_valid_o), 32'd0);

    // CLR mid-group with a coincident raw bit: partial group and counters discarded.
    send_bits(5'd31, 5'd31, 3, 1'b0, 1'b0);
    clr_i       = 1'b1;
    raw_valid_i = 1'b1;
    raw_bit_i   = 2'b11;
    tick();
    clr_i       = 1'b0;
    raw_valid_i = 1'b0;
    raw_bit_i   = '0;
    check("clr_drop_cnt", 32'(drop_cnt_o), 32'd0);
    check("clr_ovf", 32'(ovf_o), 32'd0);
    check("clr_level", 32'(level_o), 32'd0);
    send_bits(5'd1, 5'd1, 5, 1'b0, 1'b0);
    check("clr_no_early_word", 32'(d_valid_o), 32'd0);
    tick();
    check("clr_word_valid", 32'(d_valid_o), 32'd1);
    check("clr_word_data", 32'(d_out_o), 32'h00);
    check("clr_word_level", 32'(level_o), 32'd1);
    pop_one();

    // Full FIFO with push and pop on the same edge: nothing dropped.
    for (int k = 0; k < 4; k++) send_bits(5'(k), 5'd0, 5, 1'b0, 1'b0);
    send_bits(5'd6, 5'd0, 5, 1'b0, 1'b0);
    check("pp_full_level", 32'(level_o), 32'd4);
    pop_one();
    check("pp_level_held", 32'(level_o), 32'd4);
    check("pp_drop_cnt", 32'(drop_cnt_o), 32'd0);
    check("pp_ovf", 32'(ovf_o), 32'd0);
    begin
      logic [7:0] exp_pp [4];
      exp_pp = '{8'h90, 8'h94, 8'h9B, 8'h93};
      for (int k = 0; k < 4; k++) begin
        check($sformatf("pp_out%0d_data", k), 32'(d_out_o), 32'(exp_pp[k]));
        pop_one();
      end
    end
    check("pp_drained_valid", 32'(d_valid_o), 32'd0);

    // Asynchronous reset mid-group.
    send_bits(5'd31, 5'd31, 3, 1'b0, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #2;
    rst_n_i = 1'b1;
    tick();
    send_bits(5'd1, 5'd1, 5, 1'b0, 1'b0);
    check("rst_no_early_word", 32'(d_valid_o), 32'd0);
    tick();
    check("rst_word_valid", 32'(d_valid_o), 32'd1);
    check("rst_word_data", 32'(d_out_o), 32'h00);
    check("rst_word_level", 32'(level_o), 32'd1);
    pop_one();
    check("rst_drained", 32'(level_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
